npc_gen: RTL and testbench
==========================

# npc_gen

Parametrised next-PC generator at the head of the PRE_IF stage. It owns the architectural fetch PC register and selects among N prioritised redirect channels (exception, ERET, refetch, mispredict, …), the branch predictor target, and the sequential fetch-aligned increment. It issues PCs to IF over a valid/ready handshake and buffers redirects that arrive while IF cannot accept a change of address.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- FETCH_BYTES, 8, bytes per fetch group; power of two, ≥4.
- NUM_REDIR, 4, number of redirect channels; channel 0 has the highest priority.
- RESET_PC, 32'hBFC0_0000, PC presented after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- redir_valid  in  NUM_REDIR  per-channel redirect request, single-cycle pulse.
- redir_target  in  NUM_REDIR×ADDR_W  per-channel target; channel i occupies bits [i*ADDR_W +: ADDR_W].
- bpu_valid  in  1  predictor hit for the PC firing this cycle.
- bpu_target  in  ADDR_W  predicted target.
- if_hold  in  1  IF is mid-transaction; the PC register must not change.
- pc_ready  in  1  IF accepts pc this cycle.
- pc_valid  out  1  pc is valid.
- pc  out  ADDR_W  current fetch PC.
- pc_src  out  $clog2(NUM_REDIR)+2  source that produced the current pc (pc_src_e encoding).
- redir_pending  out  1  a buffered redirect is waiting for if_hold to drop.
- flush_if  out  1  one-cycle pulse; the previously fired PC's fetch must be discarded.

## Operation
- Sources, highest priority first: active redirect channels in index order, then the pending buffer, then bpu_valid (only on a fire), then the sequential increment (only on a fire).
- Sequential next = (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, wrapping modulo 2^ADDR_W.
- FSM states: RUN and PEND.
- In RUN with if_hold=0:
  - Any redirect_valid loads pc with the winning target next cycle, regardless of pc_ready (an unfired pc may be replaced), and pulses flush_if.
  - Otherwise a fire (pc_valid & pc_ready) loads the BPU target or the sequential next.
  - Otherwise pc holds.
- In RUN with if_hold=1:
  - pc is frozen.
  - A redirect is captured into the pending buffer (target plus channel index); transition to PEND.
- In PEND:
  - A new redirect with channel index ≤ the buffered index overwrites the buffer. A lower-priority redirect is dropped.
  - On the first cycle with if_hold=0, the buffer (or a same-cycle redirect of higher or equal priority) loads pc, flush_if pulses, and the FSM returns to RUN.
  - bpu_valid is ignored in PEND and on any cycle a redirect is applied.
- pc_valid stays 1 after reset. The pc payload changes only on a fire or a redirect application.
- redir_pending = (state == PEND).
- Reset values: pc=RESET_PC, pc_valid=1, pc_src=SRC_RESET, state=RUN, redir_pending=0, flush_if=0, buffer cleared.

## Timing
- Redirect to new pc: 1 cycle when if_hold=0. With if_hold high, the redirect lands 1 cycle after if_hold falls.
- Fire to next pc: 1 cycle.
- flush_if is asserted in the same cycle the redirected pc first appears.
- Simultaneous redirects on several channels: the lowest index wins; the others are discarded, not queued.
- Redirect in the same cycle as a fire: the redirect wins, and the fired PC is flushed.
- resetn low mid-PEND: the buffer is dropped, and RESET_PC is presented next cycle.
- Unaligned redirect targets are passed through unchanged. Only the sequential path aligns.

## Structure
- Shared package npc_pkg holds:
  - pc_src_e enum: SRC_RESET, SRC_SEQ, SRC_BPU, SRC_REDIR0…; the width follows NUM_REDIR.
  - The npc_state_e enum {RUN, PEND}.
  - Default RESET_PC.
- Sub-module redir_arbiter: a combinational fixed-priority encoder returning {any, index, target}. It is instantiated twice: once on live requests, and once for the compare against the buffered index.

## Test plan
- Reset release, pc_ready=1 continuously → pc sequence BFC0_0000, BFC0_0008, BFC0_0010; pc_src=SEQ after the first fire.
- bpu_valid with bpu_target=8000_0100 on a fire of BFC0_0008 → next pc=8000_0100, pc_src=BPU; a subsequent fire gives 8000_0108.
- redir_valid[3] and [1] together (targets 1111_0000 and 2222_0000), pc_ready=0 → next pc=2222_0000, flush_if=1 for one cycle, pc_src=REDIR1.
- if_hold=1 for 4 cycles:
  - redir[2] in cycle 1, then redir[3] in cycle 2 (dropped), then redir[0] in cycle 3 (overwrites).
  - Required: pc frozen throughout, redir_pending=1.
  - After if_hold falls: pc=redir[0] target, pending cleared.
- pc=FFFF_FFF8 fires → next pc=0000_0000 (wrap). Unaligned redirect 8000_0004 → pc=8000_0004, then a fire gives 8000_0008.
- resetn low during PEND → next cycle pc=RESET_PC, redir_pending=0, flush_if=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC generator.
// The pc_src_e encoding: redirect channel i is reported as SRC_REDIR0 + i.
package npc_pkg;

    typedef enum logic [7:0] {
        SRC_RESET  = 8'd0,
        SRC_SEQ    = 8'd1,
        SRC_BPU    = 8'd2,
        SRC_REDIR0 = 8'd3
    } pc_src_e;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } npc_state_e;

    localparam logic [0:0]  ST_RUN       = 1'b0;
    localparam logic [0:0]  ST_PEND      = 1'b1;
    localparam logic [31:0] NPC_RESET_PC = 32'hBFC0_0000;

    function automatic logic [7:0] src_of_redir(input logic [7:0] idx);
        return 8'(SRC_REDIR0) + idx;
    endfunction

endpackage

// File: rtl/npc_gen_redir_arbiter.sv
// Combinational fixed-priority encoder over redirect channels.
// The lowest-indexed active channel wins.
module redir_arbiter #(
    parameter int NUM    = 4,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic [NUM-1:0]        req_i,
    input  logic [NUM*ADDR_W-1:0] tgt_i,
    output logic                  any_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic [ADDR_W-1:0]     tgt_o
);

    // Scan from the lowest priority upward so the last active channel seen is the winner.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        tgt_o = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            any_o = any_o | req_i[i];
            idx_o = req_i[i] ? IDX_W'(i) : idx_o;
            tgt_o = req_i[i] ? tgt_i[i*ADDR_W +: ADDR_W] : tgt_o;
        end
    end

endmodule

// File: rtl/npc_gen.sv
// Next-PC generator: owns the fetch PC, arbitrates redirects, predictor and
// sequential paths, and buffers a redirect while IF holds its address.
module npc_gen
    import npc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                FETCH_BYTES = 8,
    parameter int                NUM_REDIR   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(NPC_RESET_PC)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REDIR-1:0]            redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0]     redir_target,
    input  logic                            bpu_valid,
    input  logic [ADDR_W-1:0]               bpu_target,
    input  logic                            if_hold,
    input  logic                            pc_ready,
    output logic                            pc_valid,
    output logic [ADDR_W-1:0]               pc,
    output logic [$clog2(NUM_REDIR)+2-1:0]  pc_src,
    output logic                            redir_pending,
    output logic                            flush_if
);

    localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam int SRC_W = $clog2(NUM_REDIR) + 2;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] buf_tgt_q, buf_tgt_d;
    logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
    logic              flush_q, flush_d;
    logic              valid_q;

    logic                 live_any_s, cmp_any_s, fire_s;
    logic [IDX_W-1:0]     live_idx_s, cmp_idx_s, sel_idx_s;
    logic [ADDR_W-1:0]    live_tgt_s, cmp_tgt_s, sel_tgt_s, seq_s;
    logic [NUM_REDIR-1:0] cmp_req_s;

    redir_arbiter #(.NUM(NUM_REDIR), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_arb_live (
        .req_i (redir_valid),
        .tgt_i (redir_target),
        .any_o (live_any_s),
        .idx_o (live_idx_s),
        .tgt_o (live_tgt_s)
    );

    // Only redirects at or above the buffered priority may replace the buffer.
    always_comb begin
        cmp_req_s = '0;
        for (int i = 0; i < NUM_REDIR; i++) begin
            cmp_req_s[i] = redir_valid[i] & (IDX_W'(i) <= buf_idx_q);
        end
    end

    redir_arbiter #(.NUM(NUM_REDIR), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_arb_cmp (
        .req_i (cmp_req_s),
        .tgt_i (redir_target),
        .any_o (cmp_any_s),
        .idx_o (cmp_idx_s),
        .tgt_o (cmp_tgt_s)
    );

    assign fire_s    = valid_q & pc_ready;
    assign seq_s     = (pc_q & ~ADDR_W'(FETCH_BYTES - 1)) + ADDR_W'(FETCH_BYTES);
    assign sel_tgt_s = cmp_any_s ? cmp_tgt_s : buf_tgt_q;
    assign sel_idx_s = cmp_any_s ? cmp_idx_s : buf_idx_q;

    // Next-state selection for pc, source tag, FSM and redirect buffer.
    always_comb begin
        pc_d      = pc_q;
        src_d     = src_q;
        state_d   = state_q;
        buf_tgt_d = buf_tgt_q;
        buf_idx_d = buf_idx_q;
        flush_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (if_hold) begin
                    if (live_any_s) begin
                        buf_tgt_d = live_tgt_s;
                        buf_idx_d = live_idx_s;
                        state_d   = ST_PEND;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end else if (live_any_s) begin
                    pc_d    = live_tgt_s;
                    src_d   = SRC_W'(src_of_redir(8'(live_idx_s)));
                    flush_d = 1'b1;
                end else if (fire_s) begin
                    pc_d  = bpu_valid ? bpu_target : seq_s;
                    src_d = bpu_valid ? SRC_W'(SRC_BPU) : SRC_W'(SRC_SEQ);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_PEND: begin
                if (if_hold) begin
                    buf_tgt_d = sel_tgt_s;
                    buf_idx_d = sel_idx_s;
                end else begin
                    pc_d      = sel_tgt_s;
                    src_d     = SRC_W'(src_of_redir(8'(sel_idx_s)));
                    flush_d   = 1'b1;
                    state_d   = ST_RUN;
                    buf_tgt_d = '0;
                    buf_idx_d = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            src_q     <= SRC_W'(SRC_RESET);
            state_q   <= ST_RUN;
            buf_tgt_q <= '0;
            buf_idx_q <= '0;
            flush_q   <= 1'b0;
            valid_q   <= 1'b1;
        end else begin
            pc_q      <= pc_d;
            src_q     <= src_d;
            state_q   <= state_d;
            buf_tgt_q <= buf_tgt_d;
            buf_idx_q <= buf_idx_d;
            flush_q   <= flush_d;
            valid_q   <= 1'b1;
        end
    end

    assign pc            = pc_q;
    assign pc_src        = src_q;
    assign pc_valid      = valid_q;
    assign flush_if      = flush_q;
    assign redir_pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_npc_gen.sv
// Self-checking bench for npc_gen: directed test-plan scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_npc_gen;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int FB = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NR-1:0]   redir_valid;
    logic [NR*AW-1:0] redir_target;
    logic            bpu_valid;
    logic [AW-1:0]   bpu_target;
    logic            if_hold;
    logic            pc_ready;
    logic            pc_valid;
    logic [AW-1:0]   pc;
    logic [3:0]      pc_src;
    logic            redir_pending;
    logic            flush_if;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model state
    longint m_pc;
    int     m_src;
    bit     m_pend;
    longint m_buf_tgt;
    int     m_buf_idx;
    bit     m_flush;

    npc_gen #(.ADDR_W(AW), .FETCH_BYTES(FB), .NUM_REDIR(NR), .RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .bpu_valid     (bpu_valid),
        .bpu_target    (bpu_target),
        .if_hold       (if_hold),
        .pc_ready      (pc_ready),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .pc_src        (pc_src),
        .redir_pending (redir_pending),
        .flush_if      (flush_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural next-state rule applied on every rising edge.
    task automatic model_step();
        int win;
        if (!resetn) begin
            m_pc = 64'hBFC0_0000; m_src = 0; m_pend = 0;
            m_buf_tgt = 0; m_buf_idx = 0; m_flush = 0;
        end else begin
            win = -1;
            for (int i = NR - 1; i >= 0; i--) if (redir_valid[i]) win = i;
            m_flush = 0;
            if (m_pend) begin
                if (win >= 0 && win <= m_buf_idx) begin
                    m_buf_idx = win;
                    m_buf_tgt = longint'(redir_target[win*AW +: AW]);
                end
                if (!if_hold) begin
                    m_pc = m_buf_tgt; m_src = 3 + m_buf_idx; m_flush = 1; m_pend = 0;
                    m_buf_tgt = 0; m_buf_idx = 0;
                end
            end else if (if_hold) begin
                if (win >= 0) begin
                    m_pend = 1; m_buf_idx = win;
                    m_buf_tgt = longint'(redir_target[win*AW +: AW]);
                end
            end else if (win >= 0) begin
                m_pc = longint'(redir_target[win*AW +: AW]); m_src = 3 + win; m_flush = 1;
            end else if (pc_ready) begin
                if (bpu_valid) begin
                    m_pc = longint'(bpu_target); m_src = 2;
                end else begin
                    m_pc = ((m_pc / FB) * FB + FB) % 64'h1_0000_0000; m_src = 1;
                end
            end
        end
    endtask

    // One clock: advance model at the edge, compare all outputs on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_pc",      64'(pc),            64'(m_pc));
        chk("m_src",     64'(pc_src),        64'(m_src));
        chk("m_valid",   64'(pc_valid),      64'd1);
        chk("m_pending", 64'(redir_pending), 64'(m_pend));
        chk("m_flush",   64'(flush_if),      64'(m_flush));
    endtask

    task automatic set_tgt(input int ch, input logic [31:0] t);
        redir_target[ch*AW +: AW] = t;
    endtask

    initial begin
        resetn = 1'b0; redir_valid = '0; redir_target = '0; bpu_valid = 1'b0;
        bpu_target = '0; if_hold = 1'b0; pc_ready = 1'b0;
        cycle(); cycle();
        chk("rst_pc", 64'(pc), 64'h0000_0000_BFC0_0000);
        chk("rst_src", 64'(pc_src), 64'd0);
        chk("rst_valid", 64'(pc_valid), 64'd1);
        chk("rst_pend", 64'(redir_pending), 64'd0);
        chk("rst_flush", 64'(flush_if), 64'd0);

        // sequential fetch
        resetn = 1'b1; pc_ready = 1'b1;
        cycle(); chk("seq1_pc", 64'(pc), 64'h0000_0000_BFC0_0008);
        chk("seq1_src", 64'(pc_src), 64'd1);
        cycle(); chk("seq2_pc", 64'(pc), 64'h0000_0000_BFC0_0010);

        // predictor hit on the fire of BFC0_0008
        resetn = 1'b0; cycle(); resetn = 1'b1;
        cycle(); chk("bpu_pre", 64'(pc), 64'h0000_0000_BFC0_0008);
        bpu_valid = 1'b1; bpu_target = 32'h8000_0100;
        cycle(); chk("bpu_pc", 64'(pc), 64'h0000_0000_8000_0100);
        chk("bpu_src", 64'(pc_src), 64'd2);
        bpu_valid = 1'b0;
        cycle(); chk("bpu_next", 64'(pc), 64'h0000_0000_8000_0108);

        // simultaneous redirects, IF not ready
        pc_ready = 1'b0; redir_valid = 4'b1010;
        set_tgt(3, 32'h1111_0000); set_tgt(1, 32'h2222_0000);
        cycle(); chk("rd_pc", 64'(pc), 64'h0000_0000_2222_0000);
        chk("rd_flush", 64'(flush_if), 64'd1);
        chk("rd_src", 64'(pc_src), 64'd4);
        redir_valid = '0;
        cycle(); chk("rd_flush_off", 64'(flush_if), 64'd0);

        // redirects buffered under if_hold
        if_hold = 1'b1; pc_ready = 1'b1;
        redir_valid = 4'b0100; set_tgt(2, 32'h3333_0000);
        cycle(); chk("h1_pc", 64'(pc), 64'h0000_0000_2222_0000);
        chk("h1_pend", 64'(redir_pending), 64'd1);
        redir_valid = 4'b1000; set_tgt(3, 32'h5555_0000);
        cycle(); chk("h2_pc", 64'(pc), 64'h0000_0000_2222_0000);
        redir_valid = 4'b0001; set_tgt(0, 32'h4444_0000);
        cycle(); chk("h3_pend", 64'(redir_pending), 64'd1);
        redir_valid = '0;
        cycle(); chk("h4_pc", 64'(pc), 64'h0000_0000_2222_0000);
        if_hold = 1'b0;
        cycle(); chk("hr_pc", 64'(pc), 64'h0000_0000_4444_0000);
        chk("hr_pend", 64'(redir_pending), 64'd0);
        chk("hr_flush", 64'(flush_if), 64'd1);
        chk("hr_src", 64'(pc_src), 64'd3);

        // wrap and unaligned redirect
        pc_ready = 1'b0; redir_valid = 4'b0100; set_tgt(2, 32'hFFFF_FFF8);
        cycle(); redir_valid = '0; pc_ready = 1'b1;
        cycle(); chk("wrap_pc", 64'(pc), 64'h0);
        pc_ready = 1'b0; redir_valid = 4'b0100; set_tgt(2, 32'h8000_0004);
        cycle(); chk("unal_pc", 64'(pc), 64'h0000_0000_8000_0004);
        redir_valid = '0; pc_ready = 1'b1;
        cycle(); chk("unal_next", 64'(pc), 64'h0000_0000_8000_0008);

        // reset during PEND
        if_hold = 1'b1; redir_valid = 4'b0010; set_tgt(1, 32'h7777_0000);
        cycle(); chk("rp_pend", 64'(redir_pending), 64'd1);
        redir_valid = '0; resetn = 1'b0;
        cycle(); chk("rp_pc", 64'(pc), 64'h0000_0000_BFC0_0000);
        chk("rp_pend0", 64'(redir_pending), 64'd0);
        chk("rp_flush", 64'(flush_if), 64'd0);
        resetn = 1'b1; if_hold = 1'b0;
        cycle();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 99) != 0);
            for (int c = 0; c < NR; c++) begin
                redir_valid[c] = ($urandom_range(0, 9) == 0);
                set_tgt(c, $urandom);
            end
            bpu_valid  = $urandom_range(0, 1) == 1;
            bpu_target = $urandom;
            if_hold    = ($urandom_range(0, 3) == 0);
            pc_ready   = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
